// File: rtl/julia_iter_engine.sv
// Julia-set escape-time engine: iterates z <- z^2 + c in signed Q(W-F).F fixed point,
// one iteration per clock, one pixel in flight, and reports the escape iteration count.
module julia_iter_engine #(
   parameter int W         = 32,
   parameter int FRAC_BITS = 12,
   parameter int X_BITS    = 10,
   parameter int Y_BITS    = 9
) (
   input  logic                 out_stream_aclk,
   input  logic                 periph_reset,
   input  logic signed [W-1:0]  cfg_c_re,
   input  logic signed [W-1:0]  cfg_c_im,
   input  logic signed [W-1:0]  cfg_x0,
   input  logic signed [W-1:0]  cfg_y0,
   input  logic signed [W-1:0]  cfg_step,
   input  logic [7:0]           cfg_max_iter,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [X_BITS-1:0]    in_x,
   input  logic [Y_BITS-1:0]    in_y,
   input  logic                 in_last,
   input  logic                 in_user,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [7:0]           out_iter,
   output logic                 out_last,
   output logic                 out_user
);

   // Handshake: a transfer happens on a clock edge where valid and ready are both high;
   // the producer holds valid and its payload steady until that edge.

   typedef enum logic [1:0] {S_IDLE, S_INIT, S_ITER, S_DONE} state_t;

   localparam logic signed [W:0] ESC_LIM = (W+1)'(4 << FRAC_BITS);

   state_t                 state_q, state_d;
   logic [X_BITS-1:0]      x_q, x_d;
   logic [Y_BITS-1:0]      y_q, y_d;
   logic                   last_q, last_d;
   logic                   user_q, user_d;
   logic signed [W-1:0]    zr_q, zr_d;
   logic signed [W-1:0]    zi_q, zi_d;
   logic [7:0]             iter_q, iter_d;
   logic [7:0]             out_iter_q, out_iter_d;

   logic signed [2*W-1:0]  zr_ext, zi_ext;
   logic signed [2*W-1:0]  zr_sq, zi_sq, zr_zi;
   logic signed [2*W-1:0]  zr_sq_sh, zi_sq_sh, zr_zi_sh;
   logic signed [W-1:0]    zr2, zi2, zri;
   logic signed [W:0]      mag;
   logic                   escape;
   logic signed [W-1:0]    x_ext, y_ext;

   // Full-width products, then floor shift back to Q format and truncate to W bits.
   always_comb begin
      zr_ext   = {{W{zr_q[W-1]}}, zr_q};
      zi_ext   = {{W{zi_q[W-1]}}, zi_q};
      zr_sq    = zr_ext * zr_ext;
      zi_sq    = zi_ext * zi_ext;
      zr_zi    = zr_ext * zi_ext;
      zr_sq_sh = zr_sq >>> FRAC_BITS;
      zi_sq_sh = zi_sq >>> FRAC_BITS;
      zr_zi_sh = zr_zi >>> (FRAC_BITS - 1);
      zr2      = zr_sq_sh[W-1:0];
      zi2      = zi_sq_sh[W-1:0];
      zri      = zr_zi_sh[W-1:0];
      mag      = {zr2[W-1], zr2} + {zi2[W-1], zi2};
      escape   = mag > ESC_LIM;
      x_ext    = {{(W-X_BITS){1'b0}}, x_q};
      y_ext    = {{(W-Y_BITS){1'b0}}, y_q};
   end

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      last_d     = last_q;
      user_d     = user_q;
      zr_d       = zr_q;
      zi_d       = zi_q;
      iter_d     = iter_q;
      out_iter_d = out_iter_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               x_d     = in_x;
               y_d     = in_y;
               last_d  = in_last;
               user_d  = in_user;
               state_d = S_INIT;
            end
         end
         S_INIT: begin
            zr_d    = cfg_x0 + x_ext * cfg_step;
            zi_d    = cfg_y0 + y_ext * cfg_step;
            iter_d  = 8'd0;
            state_d = S_ITER;
         end
         S_ITER: begin
            // Escape wins over the cap, so an escape at the cap still reports max_iter.
            if (escape || (iter_q == cfg_max_iter)) begin
               out_iter_d = iter_q;
               state_d    = S_DONE;
            end else begin
               zr_d   = zr2 - zi2 + cfg_c_re;
               zi_d   = zri + cfg_c_im;
               iter_d = iter_q + 8'd1;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge out_stream_aclk) begin
      if (periph_reset) begin
         state_q    <= S_IDLE;
         x_q        <= '0;
         y_q        <= '0;
         last_q     <= 1'b0;
         user_q     <= 1'b0;
         zr_q       <= '0;
         zi_q       <= '0;
         iter_q     <= 8'd0;
         out_iter_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         last_q     <= last_d;
         user_q     <= user_d;
         zr_q       <= zr_d;
         zi_q       <= zi_d;
         iter_q     <= iter_d;
         out_iter_q <= out_iter_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign out_iter  = out_iter_q;
   assign out_last  = last_q;
   assign out_user  = user_q;

endmodule

// File: tb/tb_julia_iter_engine.sv
// Directed bench for julia_iter_engine: hand-computed Q12 escape counts, latency,
// backpressure stall, mid-iteration reset and flag pass-through.
module tb_julia_iter_engine;

   localparam int W = 32;

   logic                clk = 1'b0;
   logic                periph_reset;
   logic signed [W-1:0] cfg_c_re, cfg_c_im, cfg_x0, cfg_y0, cfg_step;
   logic [7:0]          cfg_max_iter;
   logic                in_valid, in_ready;
   logic [9:0]          in_x;
   logic [8:0]          in_y;
   logic                in_last, in_user;
   logic                out_valid, out_ready;
   logic [7:0]          out_iter;
   logic                out_last, out_user;

   int n_checks = 0;
   int n_errors = 0;

   julia_iter_engine dut (
      .out_stream_aclk (clk),
      .periph_reset    (periph_reset),
      .cfg_c_re        (cfg_c_re),
      .cfg_c_im        (cfg_c_im),
      .cfg_x0          (cfg_x0),
      .cfg_y0          (cfg_y0),
      .cfg_step        (cfg_step),
      .cfg_max_iter    (cfg_max_iter),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_x            (in_x),
      .in_y            (in_y),
      .in_last         (in_last),
      .in_user         (in_user),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_iter        (out_iter),
      .out_last        (out_last),
      .out_user        (out_user)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic set_cfg(input int c_re, input int c_im, input int x0, input int y0,
                          input int step, input int max_it);
      cfg_c_re     = c_re;
      cfg_c_im     = c_im;
      cfg_x0       = x0;
      cfg_y0       = y0;
      cfg_step     = step;
      cfg_max_iter = 8'(max_it);
   endtask

   // Present one pixel, time the result, optionally stall, then take the result.
   task automatic run_pixel(input string tag, input int x, input int y, input logic last,
                            input logic user, input int exp_iter, input int stall);
      int lat;
      in_x     = 10'(x);
      in_y     = 9'(y);
      in_last  = last;
      in_user  = user;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({tag, ".busy"}, 32'(in_ready), 32'd0);
      lat = 0;
      for (int i = 0; i < 300 && !out_valid; i++) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, ".valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".lat"}, 32'(lat), 32'(exp_iter + 2));
      chk({tag, ".iter"}, 32'(out_iter), 32'(exp_iter));
      chk({tag, ".last"}, 32'(out_last), 32'(last));
      chk({tag, ".user"}, 32'(out_user), 32'(user));
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         chk({tag, ".stall_valid"}, 32'(out_valid), 32'd1);
         chk({tag, ".stall_iter"}, 32'(out_iter), 32'(exp_iter));
         chk({tag, ".stall_flags"}, {30'd0, out_last, out_user}, {30'd0, last, user});
         chk({tag, ".stall_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, ".drop"}, 32'(out_valid), 32'd0);
      chk({tag, ".idle"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      periph_reset = 1'b1;
      in_valid     = 1'b0;
      in_x         = '0;
      in_y         = '0;
      in_last      = 1'b0;
      in_user      = 1'b0;
      out_ready    = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 100);
      repeat (3) @(posedge clk);
      #1;
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.out_iter", 32'(out_iter), 32'd0);
      chk("rst.flags", {30'd0, out_last, out_user}, 32'd0);
      periph_reset = 1'b0;
      @(posedge clk); #1;

      // z stays at 0: runs to the cap of 100
      set_cfg(0, 0, 0, 0, 0, 100);
      run_pixel("zero_cap", 0, 0, 1'b0, 1'b0, 100, 0);

      // z0 = 3.0: 9.0 > 4.0 at once
      set_cfg(0, 0, 12288, 0, 0, 100);
      run_pixel("esc_now", 0, 0, 1'b0, 1'b0, 0, 0);

      // z0 = 1.5 -> 2.25 -> 5.0625 escapes at iter 1
      set_cfg(0, 0, 6144, 0, 0, 100);
      run_pixel("esc_one", 0, 0, 1'b0, 1'b0, 1, 0);

      // x=2, step 1.0 -> z0 = 2.0: |z|^2 == 4.0 exactly is not an escape; 4.0 then escapes
      set_cfg(0, 0, 0, 0, 4096, 100);
      run_pixel("boundary", 2, 0, 1'b0, 1'b0, 1, 0);

      // y=1 -> z0 = i: i, -1, 1, 1, ... never escapes
      set_cfg(0, 0, 0, 0, 4096, 5);
      run_pixel("imag_cap", 0, 1, 1'b0, 1'b0, 5, 0);

      // z0 = -2.0 -> 4.0 escapes at iter 1
      set_cfg(0, 0, -8192, 0, 0, 100);
      run_pixel("neg_x0", 0, 0, 1'b0, 1'b0, 1, 0);

      // c = -2: 0, -2, 2, 2, ... bounded
      set_cfg(-8192, 0, 0, 0, 0, 10);
      run_pixel("c_re_neg", 0, 0, 1'b0, 1'b0, 10, 0);

      // c = i: 0, i, -1+i, -i, -1+i, ... bounded, exercises negative cross term
      set_cfg(0, 4096, 0, 0, 0, 20);
      run_pixel("c_im_cycle", 0, 0, 1'b0, 1'b0, 20, 0);

      // Escape coinciding with the cap reports the cap
      set_cfg(0, 0, 6144, 0, 0, 1);
      run_pixel("esc_at_cap", 0, 0, 1'b0, 1'b0, 1, 0);

      // max_iter = 0 gives 0 for bounded and escaping starts
      set_cfg(0, 0, 0, 0, 0, 0);
      run_pixel("max0_bnd", 0, 0, 1'b0, 1'b0, 0, 0);
      set_cfg(0, 0, 12288, 0, 0, 0);
      run_pixel("max0_esc", 3, 4, 1'b0, 1'b0, 0, 0);

      // Backpressure: result held for 20 cycles
      set_cfg(0, 0, 6144, 0, 0, 100);
      run_pixel("stall", 7, 9, 1'b1, 1'b1, 1, 20);

      // Flags follow only their own pixel
      set_cfg(0, 0, 12288, 0, 0, 50);
      run_pixel("flag_user", 0, 0, 1'b0, 1'b1, 0, 0);
      run_pixel("flag_none", 5, 0, 1'b0, 1'b0, 0, 0);
      run_pixel("flag_last", 639, 0, 1'b1, 1'b0, 0, 0);

      // Reset in the middle of a long iteration run
      set_cfg(0, 0, 0, 0, 0, 100);
      in_x     = 10'd0;
      in_y     = 9'd0;
      in_last  = 1'b1;
      in_user  = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("mid.busy", 32'(in_ready), 32'd0);
      periph_reset = 1'b1;
      @(posedge clk); #1;
      periph_reset = 1'b0;
      chk("mid_rst.out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst.in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst.out_iter", 32'(out_iter), 32'd0);
      set_cfg(0, 0, 6144, 0, 0, 100);
      run_pixel("after_rst", 1, 1, 1'b0, 1'b1, 1, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
